maze_carver: RTL



---
 rtl/maze_pkg.sv | 45 ++++
 rtl/maze_lfsr16.sv | 32 +++
 rtl/maze_carver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze carver.
// Directions, carver states, LFSR taps and the direction picker.
package maze_pkg;

    localparam int unsigned W_DEF = 16;
    localparam int unsigned H_DEF = 12;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    // Right-shifting Fibonacci form: taps 16,14,13,11 sit on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] SEED_FALLBACK = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEED,
        ST_PICK,
        ST_STEP,
        ST_POP,
        ST_DONE
    } state_e;

    // First set mask bit scanning N->E->S->W cyclically from start.
    function automatic dir_e pick_dir(input logic [3:0] mask,
                                      input logic [1:0] start);
        logic [1:0] idx;
        logic       hit;
        pick_dir = dir_e'(start);
        hit      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!hit && mask[idx]) begin
                pick_dir = dir_e'(idx);
                hit      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reloaded with SEED on reset.
// Ports: clk, rst_n (sync, active-low), q[15:0] current state.
module maze_lfsr16
    import maze_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_FALLBACK
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    // An all-zero state would lock the register up.
    localparam logic [15:0] INIT = (SEED == 16'h0) ? SEED_FALLBACK : SEED;

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/maze_carver.sv
// Depth-first backtracking maze generator with wall map read port.
// Ports: clk, rst_n, carve/finished_carve handshake, busy, maze_valid, rd_x/rd_y -> rd_wall_right/rd_wall_down.
module maze_carver
    import maze_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned H    = H_DEF,
    parameter logic [15:0] SEED = SEED_FALLBACK
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   carve,
    output logic                   finished_carve,
    output logic                   busy,
    output logic                   maze_valid,
    // One spare code per axis so out-of-range coordinates are expressible.
    input  logic [$clog2(W+1)-1:0] rd_x,
    input  logic [$clog2(H+1)-1:0] rd_y,
    output logic                   rd_wall_right,
    output logic                   rd_wall_down
);

    localparam int N   = W * H;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    // Storage rounded up to a power of two so every index is in range.
    localparam int NP  = 1 << IW;
    localparam int SPW = $clog2(N + 1);

    state_e         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [IW-1:0]  clr_q, clr_d;
    logic           valid_q, valid_d;

    dir_e           dir_q;
    logic [IW-1:0]  nbr_q;
    logic [NP-1:0]  wall_r_q, wall_d_q, visited_q;
    logic [IW-1:0]  stack_q [NP];

    logic [15:0]    lfsr;
    logic           lfsr_unused;
    logic [IW-1:0]  cur;
    int unsigned    cx, cy;
    logic [IW-1:0]  nidx [4];
    logic [3:0]     mask;
    dir_e           dir_pick;

    maze_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:2];

    // Top-of-stack cell and its unvisited neighbours.
    always_comb begin
        cur         = stack_q[IW'(sp_q - SPW'(1))];
        cx          = 32'(cur) % W;
        cy          = 32'(cur) / W;
        nidx[DIR_N] = IW'(32'(cur) - W);
        nidx[DIR_E] = IW'(32'(cur) + 1);
        nidx[DIR_S] = IW'(32'(cur) + W);
        nidx[DIR_W] = IW'(32'(cur) - 1);
        mask        = 4'b0;
        if (cy > 0)     mask[DIR_N] = ~visited_q[nidx[DIR_N]];
        if (cx < W - 1) mask[DIR_E] = ~visited_q[nidx[DIR_E]];
        if (cy < H - 1) mask[DIR_S] = ~visited_q[nidx[DIR_S]];
        if (cx > 0)     mask[DIR_W] = ~visited_q[nidx[DIR_W]];
        dir_pick    = pick_dir(mask, lfsr[1:0]);
    end

    assign busy = state_q inside {ST_CLEAR, ST_SEED, ST_PICK,
                                  ST_STEP, ST_POP};

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        clr_d   = clr_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (carve) begin
                    state_d = ST_CLEAR;
                    clr_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_d = clr_q + IW'(1);
                if (clr_q == IW'(N - 1)) state_d = ST_SEED;
            end
            ST_SEED: begin
                sp_d    = SPW'(1);
                state_d = ST_PICK;
            end
            ST_PICK: begin
                state_d = (mask == 4'b0) ? ST_POP : ST_STEP;
            end
            ST_STEP: begin
                sp_d    = sp_q + SPW'(1);
                state_d = ST_PICK;
            end
            ST_POP: begin
                sp_d = sp_q - SPW'(1);
                if (sp_q == SPW'(1)) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_PICK;
                end
            end
            ST_DONE: begin
                if (!carve) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropping carve mid-build throws the partial maze away.
        if (busy && !carve) begin
            state_d = ST_IDLE;
            sp_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
            clr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            clr_q   <= clr_d;
            valid_q <= valid_d;
        end
    end

    // Cell array and stack are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            wall_r_q[clr_q]  <= 1'b1;
            wall_d_q[clr_q]  <= 1'b1;
            visited_q[clr_q] <= 1'b0;
        end
        if (state_q == ST_SEED) begin
            visited_q[0] <= 1'b1;
            stack_q[0]   <= '0;
        end
        if (state_q == ST_PICK) begin
            dir_q <= dir_pick;
            nbr_q <= nidx[dir_pick];
        end
        if (state_q == ST_STEP) begin
            unique case (dir_q)
                DIR_N: wall_d_q[nbr_q] <= 1'b0;
                DIR_E: wall_r_q[cur]   <= 1'b0;
                DIR_S: wall_d_q[cur]   <= 1'b0;
                DIR_W: wall_r_q[nbr_q] <= 1'b0;
            endcase
            visited_q[nbr_q]      <= 1'b1;
            stack_q[sp_q[IW-1:0]] <= nbr_q;
        end
    end

    assign maze_valid     = valid_q;
    assign finished_carve = (state_q == ST_DONE) && carve;

    logic [IW-1:0] ridx;
    logic          rd_in;

    always_comb begin
        rd_in         = (32'(rd_x) < W) && (32'(rd_y) < H);
        ridx          = IW'(32'(rd_y) * W + 32'(rd_x));
        rd_wall_right = 1'b1;
        rd_wall_down  = 1'b1;
        if (valid_q && rd_in) begin
            if (32'(rd_x) != W - 1) rd_wall_right = wall_r_q[ridx];
            if (32'(rd_y) != H - 1) rd_wall_down  = wall_d_q[ridx];
        end
    end

endmodule
